// File: rtl/seg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg_pkg : shared constants and types for the seven-segment scanner     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package seg_pkg;

    localparam int NUM_SEGS = 7;

    typedef logic [NUM_SEGS-1:0] seg_glyph_t;

    // Bit order is g..a, so bit 0 drives segment a.
    localparam seg_glyph_t C_GLYPH_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage
`default_nettype wire

// File: rtl/seg_hex_glyph.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg_hex_glyph : combinational nibble to hex seven-segment glyph       |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module seg_hex_glyph
    import seg_pkg::*;
(
    input  logic [3:0]  nibble,
    output seg_glyph_t  seg
);

    assign seg = C_GLYPH_LUT[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg_scan_driver : time-multiplexed, double-buffered hex display driver |
// | Optional macro SEG_BRIGHTNESS_EN adds a 4-bit duty-cycle input.        |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = $clog2(REFRESH_DIV)
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
`ifdef SEG_BRIGHTNESS_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_SEGS-1:0]     seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int                 C_IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]   C_DIV_MAX  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]          div_q, div_d;
    logic [C_IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   act_q, act_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0]   pend_q, pend_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                      pend_valid_q, pend_valid_d;
    logic [NUM_SEGS-1:0]       seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     digit_sel_q, digit_sel_d;
    logic                      frame_done_q, frame_done_d;

    logic                      w_tc;
    logic                      w_boundary;
    logic [3:0]                w_nibble;
    logic                      w_dp_cur;
    logic                      w_blank_cur;
    logic                      w_bright_on;
    seg_glyph_t                w_glyph;
    logic [NUM_DIGITS-1:0]     w_blank;
    logic [NUM_DIGITS:1]       w_zero_above;

    // A digit is blanked only when it and every more significant nibble are zero.
    assign w_zero_above[NUM_DIGITS] = 1'b1;
    assign w_blank[0]               = 1'b0;

    generate
        for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
            assign w_zero_above[k] = w_zero_above[k+1] && (act_q[4*k +: 4] == 4'h0);
            assign w_blank[k]      = blank_lz && w_zero_above[k];
        end
    endgenerate

    always_comb begin
        w_nibble    = 4'h0;
        w_dp_cur    = 1'b0;
        w_blank_cur = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == C_IDX_W'(k)) begin
                w_nibble    = act_q[4*k +: 4];
                w_dp_cur    = act_dp_q[k];
                w_blank_cur = w_blank[k];
            end
        end
    end

    seg_hex_glyph u_glyph (
        .nibble (w_nibble),
        .seg    (w_glyph)
    );

`ifdef SEG_BRIGHTNESS_EN
    logic [31:0] w_bright_lim;
    assign w_bright_lim = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) / 32'd16;
    assign w_bright_on  = (32'(div_q) < w_bright_lim);
`else
    assign w_bright_on  = 1'b1;
`endif

    assign w_tc       = enable && (div_q == C_DIV_MAX);
    assign w_boundary = w_tc && (idx_q == C_LAST_IDX);

    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (enable) begin
            if (w_tc) begin
                div_d = '0;
                idx_d = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Active data only changes at the frame boundary, so a frame never tears.
    always_comb begin
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        act_d        = act_q;
        act_dp_d     = act_dp_q;
        if (load) begin
            pend_d       = data_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
        if (w_boundary) begin
            if (load) begin
                act_d        = data_in;
                act_dp_d     = dp_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_d        = pend_q;
                act_dp_d     = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        seg_d        = (enable && !w_blank_cur) ? w_glyph : '0;
        dp_d         = enable && w_dp_cur;
        digit_sel_d  = (enable && w_bright_on) ? (NUM_DIGITS'(1) << idx_q) : '0;
        frame_done_d = w_boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            act_q        <= '0;
            act_dp_q     <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            act_dp_q     <= act_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_seg_scan_driver : randomized bench with a frame-position model      |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           load = 1'b0;
    logic [4*N-1:0] data_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic           blank_lz = 1'b0;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   digit_sel;
    logic           frame_done;
`ifdef SEG_BRIGHTNESS_EN
    logic [3:0]     brightness = 4'd15;
`endif

    seg_scan_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
`ifdef SEG_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph_tab [16];

    // Model: position within the frame counted in enabled clocks, plus buffers.
    int          pos;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_dpa, m_dpp;
    bit          m_pv;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos    = 0;
        m_act  = '0;
        m_pend = '0;
        m_dpa  = '0;
        m_dpp  = '0;
        m_pv   = 1'b0;
    endtask

    task automatic step();
        int          idx;
        bit          tc, bnd, blank, ld;
        logic [3:0]  nib;
        logic [15:0] d;
        logic [3:0]  p;
        logic [6:0]  e_seg;
        logic [3:0]  e_sel;
        logic        e_dp;
        idx   = (pos / DIV) % N;
        tc    = enable && ((pos % DIV) == DIV - 1);
        bnd   = tc && (idx == N - 1);
        nib   = 4'(m_act >> (4 * idx));
        blank = blank_lz && (idx >= 1) && ((m_act >> (4 * idx)) == 16'h0);
        e_sel = enable ? 4'(1 << idx) : 4'h0;
        e_seg = (enable && !blank) ? glyph_tab[nib] : 7'h00;
        e_dp  = enable && m_dpa[idx];
        ld    = load;
        d     = data_in;
        p     = dp_in;
        @(posedge clk);
        #1;
        check_val("digit_sel", 32'(digit_sel), 32'(e_sel));
        check_val("seg", 32'(seg), 32'(e_seg));
        check_val("dp", 32'(dp), 32'(e_dp));
        check_val("frame_done", 32'(frame_done), 32'(bnd));
        if (ld) begin
            m_pend = d;
            m_dpp  = p;
            m_pv   = 1'b1;
        end
        if (bnd) begin
            if (ld) begin
                m_act = d;
                m_dpa = p;
                m_pv  = 1'b0;
            end else if (m_pv) begin
                m_act = m_pend;
                m_dpa = m_dpp;
                m_pv  = 1'b0;
            end
        end
        if (enable) pos = (pos + 1) % FRAME;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int p);
        for (int i = 0; i < 2 * FRAME && pos != p; i++) step();
        if (pos != p) check_val("run_until", 32'(pos), 32'(p));
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    initial begin
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_seg", 32'(seg), 32'h0);
        check_val("rst_digit_sel", 32'(digit_sel), 32'h0);
        check_val("rst_dp", 32'(dp), 32'h0);
        check_val("rst_frame_done", 32'(frame_done), 32'h0);

        rst_n  = 1'b1;
        enable = 1'b1;
        step();
        check_val("first_sel", 32'(digit_sel), 32'h1);
        check_val("first_seg", 32'(seg), 32'h3F);
        run(2 * FRAME - 1);

        // Mid-frame load: old value must hold until the boundary.
        run_until(5);
        pulse_load(16'h12AF, 4'b0100);
        run(2 * FRAME);

        // Two loads in one frame, latest wins.
        run_until(3);
        pulse_load(16'h1111, 4'b0000);
        run(2);
        pulse_load(16'h2222, 4'b0000);
        run(2 * FRAME);

        // Load exactly on the boundary cycle.
        run_until(FRAME - 1);
        pulse_load(16'h3C5E, 4'b1001);
        run(FRAME);

        blank_lz = 1'b1;
        pulse_load(16'h0050, 4'b0000);
        run(2 * FRAME);
        pulse_load(16'h0000, 4'b1100);
        run(2 * FRAME);
        pulse_load(16'h0800, 4'b0000);
        run(2 * FRAME);
        blank_lz = 1'b0;

        // Pause mid-slot for 10 clocks, loading while disabled.
        run_until(6);
        enable = 1'b0;
        run(4);
        pulse_load(16'hABCD, 4'b0010);
        run(5);
        enable = 1'b1;
        run(2 * FRAME);

        // Asynchronous reset mid-frame.
        run_until(9);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_seg", 32'(seg), 32'h0);
        check_val("arst_digit_sel", 32'(digit_sel), 32'h0);
        check_val("arst_dp", 32'(dp), 32'h0);
        check_val("arst_frame_done", 32'(frame_done), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run(FRAME);

        for (int i = 0; i < 600; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 7) == 0);
            data_in  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) data_in = data_in & 16'h00FF;
            dp_in    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for NUM_DIGITS common-cathode seven-segment digits sharing one segment bus.
- Holds a double-buffered hex value and scans one digit per refresh slot.
- Decodes each nibble to standard hex glyphs, with optional leading-zero blanking and per-digit decimal points.
- Sits between the register/data path and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (1..8).
- REFRESH_DIV, 50000: clk cycles per digit slot (>=2).
- DIV_W, $clog2(REFRESH_DIV): width of the slot divider.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan enable; low freezes counters and blanks outputs
- load  in  1  single-cycle strobe capturing data_in/dp_in into the pending buffer
- data_in  in  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant
- dp_in  in  NUM_DIGITS  decimal point per digit, active-high
- blank_lz  in  1  leading-zero blanking enable
- seg  out  7  seg[0]=a ... seg[6]=g, active-high, registered
- dp  out  1  decimal point of the current digit, registered
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high, registered
- frame_done  out  1  one-cycle pulse when digit NUM_DIGITS-1's slot ends

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - seg=0, dp=0, digit_sel=0, frame_done=0
  - div=0, idx=0, active/pending buffers=0, pend_valid=0
- Divider: while enable=1, div counts 0..REFRESH_DIV-1. At terminal count (tc), div returns to 0 and idx advances, wrapping NUM_DIGITS-1 -> 0.
- Outputs update one cycle after idx/active change:
  - digit_sel = 1<<idx
  - seg = glyph(active nibble idx), or 0 if the digit is blanked
  - dp = active_dp[idx]
- First cycle after reset release with enable=1: digit_sel=...0001, seg=0x3F (glyph 0).
- Glyphs (hex value g..a):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Double buffering:
  - load writes pending and sets pend_valid; a later load before the boundary overwrites it (latest wins).
  - Frame boundary = tc while idx=NUM_DIGITS-1. At the boundary, if pend_valid, active<=pending and pend_valid clears.
  - load coincident with the boundary: data_in/dp_in go straight to active and pend_valid clears.
  - No display tearing mid-frame.
- Leading-zero blanking: with blank_lz=1, digit k (k>=1) is blanked when active nibbles NUM_DIGITS-1 down to k are all zero. Digit 0 is never blanked. dp is still driven on blanked digits. Blanking is evaluated combinationally on active data.
- frame_done: registered, asserted the cycle after the frame boundary tc.
- enable=0:
  - div/idx hold.
  - seg, dp, digit_sel, frame_done are forced to 0 the next cycle.
  - load still updates pending.
  - Scanning resumes from the held idx/div.
- Reset mid-frame returns all state to reset values immediately, asynchronously.

Optional Feature:
- Macro: SEG_BRIGHTNESS_EN.
- Defined:
  - Adds input brightness[3:0].
  - digit_sel is driven only while div < ((brightness+1)*REFRESH_DIV)/16, and is 0 for the rest of the slot.
  - brightness=15 gives full duty. brightness is sampled every cycle.
- Undefined: no brightness port; digit_sel stays asserted for the full slot.

Decomposition:
- Package seg_pkg:
  - NUM_SEGS=7 constant
  - 16-entry glyph constant array
  - seg_glyph_t typedef (logic [6:0])
- Sub-module seg_hex_glyph: combinational, nibble[3:0] -> seg[6:0]. Instantiated once on the idx-muxed nibble.
- Top holds the divider, scan index, buffers, blanking and output registers.

Test Plan:
- Bench configuration: NUM_DIGITS=4, REFRESH_DIV=4.
- Reset then enable=1, no load -> digit_sel cycles 0001,0010,0100,1000 every 4 clks; seg=0x3F on all digits; frame_done pulses every 16 clks.
- load data_in=0x12AF, dp_in=0100 mid-frame -> old value held until the boundary; then digit0..3 show 0x71, 0x77, 0x5B, 0x06; dp=1 only while digit_sel=0100.
- Two loads in one frame (0x1111 then 0x2222) -> only 0x2222 is displayed (0x5B on all digits). load on the boundary cycle -> applied that same boundary.
- blank_lz=1, data_in=0x0050 -> digits 3 and 2 show seg=0, digit1=0x6D, digit0=0x3F. data_in=0x0000 -> only digit0 shows 0x3F.
- enable low for 10 clks mid-slot -> outputs go 0 the next cycle; on re-enable, scanning continues from the same digit and div. rst_n low mid-frame -> all outputs 0 asynchronously, active buffer cleared.
- SEG_BRIGHTNESS_EN, REFRESH_DIV=16, brightness=3 -> digit_sel high for 4 of 16 clks per slot; brightness=15 -> high for 16 of 16.
